// File: rtl/reg_scoreboard.sv
// Load-hazard scoreboard for the ID stage: per-register in-flight load counters
// with a same-cycle stall request for reads of (or saturated writes to) pending loads.
module reg_scoreboard #(
  parameter int CNT_W = 2,
  parameter int TOT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             re1,
  input  logic [4:0]       raddr1,
  input  logic             re2,
  input  logic [4:0]       raddr2,
  input  logic             issue_valid,
  input  logic             issue_load,
  input  logic [4:0]       issue_waddr,
  input  logic             stall_in,
  input  logic             ld_done,
  input  logic [4:0]       ld_waddr,
  input  logic             flush,
  output logic             stall_req,
  output logic [31:0]      busy_vec,
  output logic [TOT_W-1:0] outstanding
);
  localparam logic [CNT_W-1:0] MAX = '1;

  logic [31:0][CNT_W-1:0] cnt;
  logic [31:0]            dec_vec;
  logic [31:0]            eff_busy;
  logic [31:1]            inc_vec;
  logic                   fire;
  logic                   dst_full;

  // x0 has no counter; its slot reads as an idle register
  assign cnt[0]      = '0;
  assign dec_vec[0]  = 1'b0;
  assign eff_busy[0] = 1'b0;
  assign busy_vec[0] = 1'b0;

  for (genvar r = 1; r < 32; r++) begin : g_reg
    logic ld_hit;
    assign ld_hit     = ld_done && (ld_waddr == 5'(r));
    assign inc_vec[r] = fire && (issue_waddr == 5'(r));
    // a completing load is forwarded from MEM, so the last pending one doesn't stall
    assign eff_busy[r] = (cnt[r] > CNT_W'(1)) || ((cnt[r] == CNT_W'(1)) && !ld_hit);
    assign busy_vec[r] = (cnt[r] != '0);

    reg_sb_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .flush  (flush),
      .inc    (inc_vec[r]),
      .ld_hit (ld_hit),
      .dec    (dec_vec[r]),
      .cnt    (cnt[r])
    );
  end

  assign dst_full = issue_load && (issue_waddr != 5'd0) &&
                    (cnt[issue_waddr] == MAX) && !dec_vec[issue_waddr];

  assign stall_req = !rst && issue_valid &&
                     ((re1 && eff_busy[raddr1]) || (re2 && eff_busy[raddr2]) || dst_full);

  assign fire = issue_valid && issue_load && (issue_waddr != 5'd0) &&
                !stall_req && !stall_in && !flush;

  // only one register can increment and one decrement per cycle
  always_ff @(posedge clk) begin
    if (rst || flush)
      outstanding <= '0;
    else
      outstanding <= outstanding + TOT_W'(fire) - TOT_W'(|dec_vec);
  end
endmodule

// One per-register outstanding-load counter; inc is pre-gated so it never saturates.
module reg_sb_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             inc,
  input  logic             ld_hit,
  output logic             dec,
  output logic [CNT_W-1:0] cnt
);
  assign dec = ld_hit && (cnt != '0);

  always_ff @(posedge clk) begin
    if (rst || flush)
      cnt <= '0;
    else if (inc && !dec)
      cnt <= cnt + CNT_W'(1);
    else if (dec && !inc)
      cnt <= cnt - CNT_W'(1);
  end
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed table-driven bench for reg_scoreboard plus a hand-written back-to-back load sequence.
module tb_reg_scoreboard;
  logic        clk = 1'b0;
  logic        rst, re1, re2, issue_valid, issue_load, stall_in, ld_done, flush;
  logic [4:0]  raddr1, raddr2, issue_waddr, ld_waddr;
  logic        stall_req;
  logic [31:0] busy_vec;
  logic [6:0]  outstanding;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_scoreboard #(.CNT_W(2), .TOT_W(7)) dut (
    .clk(clk), .rst(rst), .re1(re1), .raddr1(raddr1), .re2(re2), .raddr2(raddr2),
    .issue_valid(issue_valid), .issue_load(issue_load), .issue_waddr(issue_waddr),
    .stall_in(stall_in), .ld_done(ld_done), .ld_waddr(ld_waddr), .flush(flush),
    .stall_req(stall_req), .busy_vec(busy_vec), .outstanding(outstanding)
  );

  typedef struct {
    logic        rst;
    logic        iv, il;
    logic [4:0]  wa;
    logic        re1;
    logic [4:0]  ra1;
    logic        re2;
    logic [4:0]  ra2;
    logic        si;
    logic        ld;
    logic [4:0]  la;
    logic        fl;
    logic        e_stall;
    logic [31:0] e_busy;
    logic [6:0]  e_out;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic iv, input logic il, input logic [4:0] wa,
                     input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2,
                     input logic si, input logic ld, input logic [4:0] la, input logic fl,
                     input logic es, input logic [31:0] eb, input logic [6:0] eo);
    vec_t v;
    v.rst = r; v.iv = iv; v.il = il; v.wa = wa; v.re1 = e1; v.ra1 = a1; v.re2 = e2; v.ra2 = a2;
    v.si = si; v.ld = ld; v.la = la; v.fl = fl; v.e_stall = es; v.e_busy = eb; v.e_out = eo;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; issue_valid = v.iv; issue_load = v.il; issue_waddr = v.wa;
    re1 = v.re1; raddr1 = v.ra1; re2 = v.re2; raddr2 = v.ra2;
    stall_in = v.si; ld_done = v.ld; ld_waddr = v.la; flush = v.fl;
  endtask

  // drive at negedge, check stall_req combinationally, clock, check registered state
  task automatic step(input vec_t v, input int idx);
    @(negedge clk);
    drive(v);
    #1 chk("stall_req", idx, 32'(stall_req), 32'(v.e_stall));
    @(posedge clk);
    #1;
    chk("busy_vec", idx, busy_vec, v.e_busy);
    chk("outstanding", idx, 32'(outstanding), 32'(v.e_out));
  endtask

  initial begin
    vec_t v;
    drive('{default: '0});
    //   rst iv il wa   re1 ra1 re2 ra2 si ld la   fl  stall busy        out
    // reset with busy-looking inputs
    add(1, 1, 1, 5'd5,  1, 5'd5, 1, 5'd7, 0, 1, 5'd5, 0,  0, 32'h0,       7'd0);
    add(1, 1, 1, 5'd7,  0, 5'd0, 1, 5'd7, 1, 0, 5'd0, 1,  0, 32'h0,       7'd0);
    // load-use on x5
    add(0, 1, 1, 5'd5,  0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0,  0, 32'h20,      7'd1);
    add(0, 1, 0, 5'd1,  1, 5'd5, 0, 5'd0, 0, 0, 5'd0, 0,  1, 32'h20,      7'd1);
    add(0, 1, 0, 5'd1,  1, 5'd5, 0, 5'd0, 0, 0, 5'd0, 0,  1, 32'h20,      7'd1);
    add(0, 1, 0, 5'd1,  1, 5'd5, 0, 5'd0, 0, 1, 5'd5, 0,  0, 32'h0,       7'd0);
    // saturation on x7
    add(0, 1, 1, 5'd7,  0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0,  0, 32'h80,      7'd1);
    add(0, 1, 1, 5'd7,  0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0,  0, 32'h80,      7'd2);
    add(0, 1, 1, 5'd7,  0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0,  0, 32'h80,      7'd3);
    add(0, 1, 1, 5'd7,  0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0,  1, 32'h80,      7'd3);
    add(0, 1, 1, 5'd7,  0, 5'd0, 0, 5'd0, 0, 1, 5'd7, 0,  0, 32'h80,      7'd3);
    // read of x7 with count 3 still stalls despite a completion
    add(0, 1, 0, 5'd1,  0, 5'd0, 1, 5'd7, 0, 1, 5'd7, 0,  1, 32'h80,      7'd2);
    add(0, 0, 0, 5'd0,  0, 5'd0, 0, 5'd0, 0, 1, 5'd7, 0,  0, 32'h80,      7'd1);
    add(0, 1, 0, 5'd1,  1, 5'd7, 0, 5'd0, 0, 1, 5'd7, 0,  0, 32'h0,       7'd0);
    // simultaneous fire/complete on x9, stray completion, stall_in blocks fire
    add(0, 1, 1, 5'd9,  0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0,  0, 32'h200,     7'd1);
    add(0, 1, 1, 5'd9,  0, 5'd0, 0, 5'd0, 0, 1, 5'd9, 0,  0, 32'h200,     7'd1);
    add(0, 1, 1, 5'd9,  0, 5'd0, 0, 5'd0, 1, 1, 5'd12,0,  0, 32'h200,     7'd1);
    add(0, 0, 0, 5'd0,  0, 5'd0, 0, 5'd0, 0, 1, 5'd9, 0,  0, 32'h0,       7'd0);
    // flush with a firing load
    add(0, 1, 1, 5'd3,  0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0,  0, 32'h8,       7'd1);
    add(0, 1, 1, 5'd4,  0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0,  0, 32'h18,      7'd2);
    add(0, 1, 1, 5'd4,  0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0,  0, 32'h18,      7'd3);
    add(0, 1, 1, 5'd6,  0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 1,  0, 32'h0,       7'd0);
    add(0, 0, 0, 5'd0,  0, 5'd0, 0, 5'd0, 0, 1, 5'd4, 0,  0, 32'h0,       7'd0);
    // x0 handling
    add(0, 1, 1, 5'd0,  1, 5'd0, 1, 5'd0, 0, 0, 5'd0, 0,  0, 32'h0,       7'd0);
    add(0, 1, 1, 5'd5,  0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0,  0, 32'h20,      7'd1);
    add(0, 1, 1, 5'd0,  1, 5'd0, 1, 5'd0, 0, 1, 5'd0, 0,  0, 32'h20,      7'd1);
    // no stall without a valid instruction; self-reference stalls; reset mid-operation
    add(0, 0, 0, 5'd0,  1, 5'd5, 1, 5'd5, 0, 0, 5'd0, 0,  0, 32'h20,      7'd1);
    add(0, 1, 1, 5'd5,  1, 5'd5, 0, 5'd0, 0, 0, 5'd0, 0,  1, 32'h20,      7'd1);
    add(1, 1, 0, 5'd1,  1, 5'd5, 1, 5'd5, 0, 0, 5'd0, 0,  0, 32'h0,       7'd0);

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

    // back-to-back loads to x10: a reader stalls through the first completion
    v = '{default: '0};
    v.iv = 1; v.il = 1; v.wa = 5'd10; v.e_busy = 32'h400; v.e_out = 7'd1;
    step(v, 100);
    v.e_out = 7'd2;
    step(v, 101);
    v = '{default: '0};
    v.iv = 1; v.re1 = 1; v.ra1 = 5'd10; v.e_stall = 1; v.e_busy = 32'h400; v.e_out = 7'd2;
    step(v, 102);
    v.ld = 1; v.la = 5'd10; v.e_out = 7'd1;
    step(v, 103);
    v.e_stall = 0; v.e_busy = 32'h0; v.e_out = 7'd0;
    step(v, 104);
    v = '{default: '0};
    v.iv = 1; v.re2 = 1; v.ra2 = 5'd10;
    step(v, 105);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Load-hazard scoreboard for the `regfile` read ports. Sits beside `regfile` in the ID stage. It tracks destination registers of issued loads whose data is not yet available for forwarding, and raises a stall request while an ID-stage source or destination conflicts with an outstanding load. It counts in-flight loads per register, so back-to-back loads to the same destination are handled. Register x0 is never tracked.

## Interface
Parameters:
- `CNT_W`, 2, width of each per-register outstanding-load counter; saturation value `MAX = 2**CNT_W - 1`.
- `TOT_W`, 7, width of the total outstanding-load count; must hold `31*MAX`.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  synchronous reset, active-high.
- `re1`  in  1  ID reads source 1.
- `raddr1`  in  5  source 1 address.
- `re2`  in  1  ID reads source 2.
- `raddr2`  in  5  source 2 address.
- `issue_valid`  in  1  ID holds a valid instruction this cycle.
- `issue_load`  in  1  that instruction is a load.
- `issue_waddr`  in  5  its destination register.
- `stall_in`  in  1  downstream stall; the ID instruction does not advance.
- `ld_done`  in  1  a load's data is valid at the MEM stage output (forwardable) this cycle.
- `ld_waddr`  in  5  destination of the completing load.
- `flush`  in  1  pipeline flush (branch or jump); all in-flight loads are discarded.
- `stall_req`  out  1  combinational; ID must hold.
- `busy_vec`  out  32  registered; bit i is 1 when counter i is not 0; bit 0 is always 0.
- `outstanding`  out  `TOT_W`  registered; sum of all counters.

## Operation
- State is 31 counters `cnt[1..31]`, each `CNT_W` bits. There is no `cnt[0]`.
- **Effective busy.** `eff_busy(a)` = (a != 0) and (`cnt[a]` > 1 or (`cnt[a]` == 1 and not (`ld_done` and `ld_waddr` == a))).
  - A load completing in the same cycle is bypassed through the `regfile` MEM forward path, so it does not cause a stall.
- **Stall request.** `stall_req` = not `rst` and `issue_valid` and any of:
  - `re1` and `eff_busy(raddr1)`.
  - `re2` and `eff_busy(raddr2)`.
  - `issue_load` and `issue_waddr` != 0 and `cnt[issue_waddr]` == `MAX` and the counter is not being decremented this cycle.
- **Fire.** `fire` = `issue_valid` and `issue_load` and `issue_waddr` != 0 and not `stall_req` and not `stall_in` and not `flush`.
- **Counter update at posedge, per register r:**
  - `inc` = `fire` and `issue_waddr` == r.
  - `dec` = `ld_done` and `ld_waddr` == r and `cnt[r]` != 0.
  - `inc` and `dec` together: counter unchanged.
  - `inc` only: +1. Saturation cannot occur because the `MAX` stall blocks it.
  - `dec` only: -1.
  - `ld_done` on a zero counter is ignored. There is no underflow, and `outstanding` is unchanged.
- **Flush.** `flush` has priority over all updates: every counter goes to 0 and the same cycle's `fire` is suppressed. Any `ld_done` arriving after a flush for discarded loads hits a 0 counter and is ignored.
- `outstanding` is updated in the same cycle as the counters: next value = sum of next counters, computed incrementally as +`inc` −`dec`.
- `busy_vec` reflects the registered counters, not effective busy.

## Timing
- **Reset** (`rst` high at posedge): all counters 0, `busy_vec` = 0, `outstanding` = 0.
  - `stall_req` is 0 combinationally while `rst` is high.
  - Reset mid-operation discards all tracked loads, the same as flush.
- **Latency.** `stall_req` responds in the same cycle to ID inputs and to `ld_done`. `busy_vec` and `outstanding` reflect a fire or completion one cycle later.
- **Dependent instruction after a load.** A load fires in cycle N. The dependent instruction in ID at N+1 stalls until the cycle its `ld_done` arrives, and issues in that cycle.
- **Self-reference.** `issue_waddr` equal to a busy source stalls because of the source check.
- **Conflicting completion and issue.** Simultaneous `ld_done` to r and `fire` to r leaves the counter unchanged and keeps r busy.
- **Destination WAW.** Destination conflicts below `MAX` do not stall, because loads complete in order.

## Test plan
- **Reset.** Hold `rst` high 2 cycles with random inputs -> `stall_req`=0, `busy_vec`=0, `outstanding`=0.
- **Load-use.** Load x5 fires at N. Add reading x5 via `re1` at N+1..N+3. `ld_done` for x5 at N+3 -> `stall_req`=1 at N+1 and N+2, 0 at N+3. `busy_vec[5]`=1 from N+1, 0 at N+4.
- **Saturation.** Three loads to x7 with no `ld_done` -> `outstanding`=3. A fourth load to x7 -> `stall_req`=1 and the counter stays 3. Same cycle with `ld_done` x7 -> no stall, counter stays 3.
- **Simultaneous events.** `fire` load x9 together with `ld_done` x9 on counter 1 -> counter stays 1, `busy_vec[9]`=1. A stray `ld_done` x12 on counter 0 -> no change.
- **Flush.** Loads to x3, x4, x4 outstanding (`outstanding`=3). `flush` with a firing load to x6 -> next cycle `busy_vec`=0 and `outstanding`=0. Later `ld_done` x4 -> no change.
- **x0 handling.** Load to x0, plus reads of x0 with `re1`/`re2` -> never stalls, `busy_vec[0]`=0, `outstanding` unchanged.
